psi_csr_array: RTL and testbench
================================

// Module: psi_csr_array
// PURPOSE
//  Avalon-MM slave CSR bank for NUM_CH independent PSI serial-engine channels; generalised, multi-channel successor
//  to the single-channel PSI register block. Provides per channel: clock divider, TX data, start pulse, latched RX
//  data, sticky DONE/ERR status. Aggregates status into one level interrupt for the Nios core. Sits between the
//  mm_bridge master and the PSI engine array.
// PARAMETERS
//  NUM_CH   4   channels instantiated, 1..8
//  DATA_W   32  PSI data width per channel, 1..32 (readdata zero-extended)
//  DIV_W    8   clock-divider width, 1..16
//  ADDR_W   8   byte-address width, >=8
// PORTS
//  clk            in   1              system clock
//  rstn           in   1              async active-low reset
//  address        in   ADDR_W         byte address, [1:0] ignored
//  read           in   1              read strobe
//  write          in   1              write strobe
//  byteenable     in   4              write byte lanes
//  writedata      in   32             write data
//  readdata       out  32             registered read data
//  readdatavalid  out  1              one cycle after read
//  waitrequest    out  1              tied 0
//  irq            out  1              |(IRQ_STATUS & IRQ_MASK), registered
//  ch_start       out  NUM_CH         1-cycle start pulse per channel
//  ch_div         out  NUM_CH*DIV_W   divider per channel
//  ch_data_in     out  NUM_CH*DATA_W  TX data per channel
//  ch_busy        in   NUM_CH         engine busy per channel
//  ch_data_out    in   NUM_CH*DATA_W  RX data per channel, valid at busy fall
// BEHAVIOUR
//  Reset (rstn): reset is asynchronous, active-low; clock is clk. All regs, readdata, readdatavalid, irq, ch_start,
//    ch_div, ch_data_in, shadows and busy_q clear to 0.
//  Map, channel c at 0x10*c: +0 CTRL, +4 DIV, +8 DATA_IN, +C DATA_OUT. Global: 0x80 IRQ_STATUS(W1C, bit c=DONE|ERR
//    of ch c), 0x84 IRQ_MASK(RW), 0x88 VERSION(RO 32'h0002_0000|NUM_CH). Unmapped/absent-channel: read 0, write ignored.
//  CTRL write: bit0=1 START, bit1=1 clear DONE, bit2=1 clear ERR (W1C). CTRL read: bit0 BUSY (live ch_busy),
//    bit1 DONE, bit2 ERR, rest 0. Requires byteenable[0] for any CTRL action.
//  START: if ch_busy[c]==0 and no pulse issued the previous cycle -> ch_start[c]=1 in the cycle after the write, for
//    exactly 1 cycle. Otherwise no pulse; ERR set.
//  DIV, DATA_IN, IRQ_MASK: byteenable-qualified writes; bits above width ignored/read 0.
//  Completion: busy_q registered; busy_q=1 & ch_busy=0 -> DATA_OUT shadow <= ch_data_out, DONE<=1 same edge.
//  DATA_OUT reads the shadow, never live input.
//  Simultaneous set and W1C clear of DONE/ERR (CTRL or IRQ_STATUS) -> set wins.
//  Read latency 1: readdata/readdatavalid valid cycle after read; read with no strobe leaves readdata holding.
//  Read and write in same cycle: write applied, read returns pre-write value.
//  irq: registered, 1 cycle after status/mask change.
//  Reset mid-transfer: pulses and status drop immediately; engine re-sync is engine's duty.
// STRUCTURE
//  psi_csr_pkg: register offsets, CTRL bit indices, VERSION constant, CH_STRIDE=0x10.
//  Sub-module psi_csr_channel (one per channel via generate): CTRL/DIV/DATA_IN regs, start gating, busy edge,
//  shadow, DONE/ERR. Top: address decode, read mux, IRQ regs.
// TESTING
//  Reset, read 0x88 -> readdata 0x00020004 next cycle, readdatavalid 1 for 1 cycle; all outputs 0 during reset.
//  Write 0x14=0x37, 0x18=0xA5A5_0001, 0x10=0x1 (busy=0) -> ch_div[1]=0x37, ch_data_in[1]=0xA5A50001,
//    ch_start[1] high exactly 1 cycle.
//  ch_busy[1] 1->0 with ch_data_out[1]=0x1234_5678 -> read 0x1C=0x12345678, 0x10=0x2, 0x80 bit1=1.
//  Write 0x84=0x2 -> irq=1; write 0x80=0x2 -> DONE clears, irq=0.
//  Write 0x20=0x1 while ch_busy[2]=1 -> no ch_start[2], CTRL read=0x5.
//  W1C of DONE same cycle as busy fall -> DONE stays 1. Byteenable 4'b0010 on DIV -> bits[15:8] only.

Source files
------------

// File: rtl/psi_csr_pkg.sv
// psi_csr_pkg: register map offsets, CTRL bit indices, VERSION constant and byte-lane merge helper
package psi_csr_pkg;
  typedef enum logic [1:0] {REG_CTRL, REG_DIV, REG_DATA_IN, REG_DATA_OUT} reg_e;
  localparam logic [7:0] CH_STRIDE = 8'h10;
  localparam logic [7:0] IRQ_STATUS_ADDR = 8'h80;
  localparam logic [7:0] IRQ_MASK_ADDR = 8'h84;
  localparam logic [7:0] VERSION_ADDR = 8'h88;
  localparam int CTRL_START = 0;
  localparam int CTRL_DONE = 1;
  localparam int CTRL_ERR = 2;
  localparam logic [31:0] VERSION_BASE = 32'h0002_0000;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/psi_csr_array_if.sv
// psi_csr_array_if: Avalon-MM bus (address/read/write/byteenable/writedata -> readdata/readdatavalid/waitrequest)
interface psi_csr_array_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [3:0] byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master(output address, read, write, byteenable, writedata, input readdata, readdatavalid, waitrequest);
  modport slave(input address, read, write, byteenable, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/psi_csr_channel.sv
// psi_csr_channel: one channel's CTRL/DIV/DATA_IN regs, start gating, busy-fall capture, sticky DONE/ERR
module psi_csr_channel import psi_csr_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_ctrl,
  input  logic              wr_div,
  input  logic              wr_data,
  input  logic              clr_irq,
  input  logic [3:0]        be,
  input  logic [31:0]       wd,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  output logic              start,
  output logic [DIV_W-1:0]  div,
  output logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] shadow,
  output logic              done,
  output logic              err
);
  logic busy_q, ctrl_ok, go, fall;
  assign ctrl_ok = wr_ctrl & be[0];
  assign go = ctrl_ok & wd[CTRL_START];
  assign fall = busy_q & ~busy;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      busy_q <= 1'b0;
      start <= 1'b0;
      div <= '0;
      data_in <= '0;
      shadow <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      busy_q <= busy;
      start <= go & ~busy & ~start;
      if (wr_div) div <= DIV_W'(be_merge(32'(div), wd, be));
      if (wr_data) data_in <= DATA_W'(be_merge(32'(data_in), wd, be));
      if (fall) shadow <= data_out;
      done <= fall | (done & ~(clr_irq | (ctrl_ok & wd[CTRL_DONE])));
      err <= (go & (busy | start)) | (err & ~(clr_irq | (ctrl_ok & wd[CTRL_ERR])));
    end
endmodule

// File: rtl/psi_csr_array.sv
// psi_csr_array: Avalon-MM CSR bank for NUM_CH PSI channels (bus slave, ch_* engine side, irq to CPU)
module psi_csr_array import psi_csr_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DIV_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  psi_csr_array_if.slave           bus,
  output logic                     irq,
  output logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH*DIV_W-1:0]  ch_div,
  output logic [NUM_CH*DATA_W-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]        ch_busy,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_out
);
  logic [ADDR_W-1:0] a;
  logic in_ch, wr_stat, wr_mask;
  logic [2:0] ch_sel;
  reg_e rsel;
  logic [NUM_CH-1:0] done, err, irq_mask, stat;
  logic [31:0] ch_word [8];
  logic [31:0] rd_val;
  assign a = bus.address & ~ADDR_W'(3);
  assign in_ch = a < ADDR_W'(IRQ_STATUS_ADDR);
  assign ch_sel = a[6:4];
  assign rsel = reg_e'(a[3:2]);
  assign wr_stat = bus.write & (a == ADDR_W'(IRQ_STATUS_ADDR)) & bus.byteenable[0];
  assign wr_mask = bus.write & (a == ADDR_W'(IRQ_MASK_ADDR));
  assign stat = done | err;
  assign bus.waitrequest = 1'b0;
  for (genvar c = 0; c < 8; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      logic wr;
      logic [DATA_W-1:0] shadow;
      assign wr = bus.write & in_ch & (ch_sel == 3'(c));
      psi_csr_channel #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_ch (
        .clk(clk), .rstn(rstn),
        .wr_ctrl(wr & (rsel == REG_CTRL)),
        .wr_div(wr & (rsel == REG_DIV)),
        .wr_data(wr & (rsel == REG_DATA_IN)),
        .clr_irq(wr_stat & bus.writedata[c]),
        .be(bus.byteenable), .wd(bus.writedata),
        .busy(ch_busy[c]), .data_out(ch_data_out[c*DATA_W +: DATA_W]),
        .start(ch_start[c]), .div(ch_div[c*DIV_W +: DIV_W]),
        .data_in(ch_data_in[c*DATA_W +: DATA_W]), .shadow(shadow),
        .done(done[c]), .err(err[c])
      );
      assign ch_word[c] = rsel == REG_CTRL ? 32'({err[c], done[c], ch_busy[c]}) :
                          rsel == REG_DIV ? 32'(ch_div[c*DIV_W +: DIV_W]) :
                          rsel == REG_DATA_IN ? 32'(ch_data_in[c*DATA_W +: DATA_W]) : 32'(shadow);
    end else begin : g_off
      assign ch_word[c] = '0;
    end
  end
  always_comb
    rd_val = in_ch ? ch_word[ch_sel] :
             a == ADDR_W'(IRQ_STATUS_ADDR) ? 32'(stat) :
             a == ADDR_W'(IRQ_MASK_ADDR) ? 32'(irq_mask) :
             a == ADDR_W'(VERSION_ADDR) ? VERSION_BASE | 32'(NUM_CH) : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.readdata <= '0;
      bus.readdatavalid <= 1'b0;
      irq_mask <= '0;
      irq <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) bus.readdata <= rd_val;
      if (wr_mask) irq_mask <= NUM_CH'(be_merge(32'(irq_mask), bus.writedata, bus.byteenable));
      irq <= |(stat & irq_mask);
    end
endmodule

// File: tb/tb_psi_csr_array.sv
// tb_psi_csr_array: table-driven register vectors plus hand sequences for start, completion, irq and W1C races
module tb_psi_csr_array;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic irq;
  logic [3:0] ch_start, ch_busy;
  logic [31:0] ch_div;
  logic [127:0] ch_data_in, ch_data_out;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [7:0] addr;
    logic wr;
    logic [3:0] be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];
  psi_csr_array_if #(.ADDR_W(8)) bus();
  psi_csr_array #(.NUM_CH(4), .DATA_W(32), .DIV_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .irq(irq), .ch_start(ch_start), .ch_div(ch_div),
    .ch_data_in(ch_data_in), .ch_busy(ch_busy), .ch_data_out(ch_data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] addr, input logic wr, input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.addr = addr; v.wr = wr; v.be = be; v.wd = wd; v.exp = exp;
    vt.push_back(v);
  endtask
  task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be = 4'hF);
    @(negedge clk);
    bus.address = addr; bus.writedata = wd; bus.byteenable = be; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  task automatic rd(input string name, input logic [7:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.address = addr; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    check({name, " data"}, 128'(bus.readdata), 128'(exp));
    check({name, " valid"}, 128'(bus.readdatavalid), 128'(1));
  endtask
  initial begin
    bus.address = '0; bus.read = 0; bus.write = 0; bus.byteenable = '0; bus.writedata = '0;
    ch_busy = '0; ch_data_out = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.readdata, 31'd0, bus.readdatavalid, 31'd0, irq, 4'd0, ch_start, ch_div}, '0);
    check("reset data_in", ch_data_in, '0);
    rstn = 1'b1;
    add(8'h88, 0, 4'h0, 0, 32'h0002_0004);
    add(8'h14, 1, 4'hF, 32'h37, 0);
    add(8'h14, 0, 4'h0, 0, 32'h37);
    add(8'h18, 1, 4'hF, 32'hA5A5_0001, 0);
    add(8'h18, 0, 4'h0, 0, 32'hA5A5_0001);
    add(8'h24, 1, 4'hF, 32'h55, 0);
    add(8'h24, 1, 4'h2, 32'hFFFF, 0);
    add(8'h24, 0, 4'h0, 0, 32'h55);
    add(8'h28, 1, 4'hF, 32'h1122_3344, 0);
    add(8'h28, 1, 4'h2, 32'hAABB_CCDD, 0);
    add(8'h28, 0, 4'h0, 0, 32'h1122_CC44);
    add(8'h04, 1, 4'hF, 32'h1FF, 0);
    add(8'h04, 0, 4'h0, 0, 32'hFF);
    add(8'h40, 1, 4'hF, 32'hDEAD_BEEF, 0);
    add(8'h40, 0, 4'h0, 0, 0);
    add(8'h8C, 0, 4'h0, 0, 0);
    add(8'h84, 1, 4'hF, 32'hFF, 0);
    add(8'h84, 0, 4'h0, 0, 32'hF);
    add(8'h84, 1, 4'hF, 32'h0, 0);
    add(8'h84, 0, 4'h0, 0, 32'h0);
    add(8'h0C, 1, 4'hF, 32'h1234_5678, 0);
    add(8'h0C, 0, 4'h0, 0, 0);
    add(8'h00, 0, 4'h0, 0, 0);
    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].wd, vt[i].be);
      else rd($sformatf("vec%0d @%h", i, vt[i].addr), vt[i].addr, vt[i].exp);
    end
    check("ch_div vector", 128'(ch_div), 128'(32'h0055_37FF));
    check("ch_data_in vector", ch_data_in, {32'h0, 32'h1122_CC44, 32'hA5A5_0001, 32'h0});
    @(negedge clk);
    check("rdv single cycle", 128'(bus.readdatavalid), 128'(0));
    check("readdata holds", 128'(bus.readdata), 128'(0));
    wr(8'h10, 32'h1);
    check("start ch1 pulse", 128'(ch_start), 128'(4'b0010));
    @(negedge clk);
    check("start ch1 one cycle", 128'(ch_start), 128'(4'b0000));
    ch_busy[1] = 1'b1; ch_data_out[63:32] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    ch_busy[1] = 1'b0;
    @(negedge clk);
    ch_data_out[63:32] = 32'hFFFF_FFFF;
    rd("data_out ch1", 8'h1C, 32'h1234_5678);
    rd("ctrl ch1 done", 8'h10, 32'h2);
    rd("irq_status done1", 8'h80, 32'h2);
    check("irq masked", 128'(irq), 128'(0));
    wr(8'h84, 32'h2);
    @(negedge clk);
    check("irq set", 128'(irq), 128'(1));
    wr(8'h80, 32'h2);
    @(negedge clk);
    check("irq cleared", 128'(irq), 128'(0));
    rd("ctrl ch1 cleared", 8'h10, 32'h0);
    ch_busy[2] = 1'b1;
    wr(8'h20, 32'h1);
    check("no start busy ch2", 128'(ch_start), 128'(0));
    rd("ctrl ch2 busy err", 8'h20, 32'h5);
    wr(8'h20, 32'h4);
    rd("ctrl ch2 err cleared", 8'h20, 32'h1);
    ch_busy[1] = 1'b1;
    repeat (2) @(negedge clk);
    ch_busy[1] = 1'b0;
    bus.address = 8'h10; bus.writedata = 32'h2; bus.byteenable = 4'hF; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    rd("ctrl w1c vs set", 8'h10, 32'h2);
    wr(8'h80, 32'h2);
    ch_busy[1] = 1'b1;
    repeat (2) @(negedge clk);
    ch_busy[1] = 1'b0;
    bus.address = 8'h80; bus.writedata = 32'h2; bus.byteenable = 4'hF; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    rd("irq_status w1c vs set", 8'h80, 32'h2);
    wr(8'h00, 32'h1);
    check("b2b first pulse", 128'(ch_start), 128'(4'b0001));
    bus.address = 8'h00; bus.writedata = 32'h1; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    check("b2b second no pulse", 128'(ch_start), 128'(0));
    rd("b2b err ch0", 8'h00, 32'h4);
    @(negedge clk);
    bus.address = 8'h14; bus.writedata = 32'h99; bus.byteenable = 4'hF; bus.write = 1'b1; bus.read = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
    check("rw same cycle old", 128'(bus.readdata), 128'(32'h37));
    rd("rw same cycle new", 8'h14, 32'h99);
    wr(8'h30, 32'h1);
    check("start ch3 pulse", 128'(ch_start), 128'(4'b1000));
    #2 rstn = 1'b0;
    #1;
    check("async reset start", 128'(ch_start), 128'(0));
    check("async reset regs", {bus.readdata, ch_div, 31'd0, irq}, '0);
    @(negedge clk);
    rstn = 1'b1;
    rd("post reset status", 8'h80, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
